hdmi_tx_config: RTL

Power-on and hot-plug configuration sequencer for the ADV7513 HDMI transmitter feeding the 640x480 scanout path. After reset it waits for the transmitter to power up, then issues a fixed list of I2C register writes: power-up, the required fixed registers, 24-bit RGB input and HDMI mode. It then flags `ready`. It drives the open-drain I2C bus through output-enable pins. It optionally re-runs the sequence when the transmitter raises `HDMI_TX_INT` on hot-plug.

---
 rtl/hdmi_tx_config.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/hdmi_tx_config.sv
// ADV7513 power-on register loader driving an open-drain I2C bus through output enables.
// Build option HDMI_CFG_HPD_EN re-runs the write sequence when HDMI_TX_INT (hot-plug) is raised.
module hdmi_tx_config #(
  parameter int unsigned CLK_DIV        = 62,
  parameter int unsigned POWERUP_CYCLES = 2500000,
  parameter int unsigned RETRIES        = 3,
  parameter logic [6:0]  DEV_ADDR       = 7'h39
) (
  input  logic clock25,
  input  logic resetn,
  output logic scl_oe,
  output logic sda_oe,
  input  logic sda_in,
  input  logic HDMI_TX_INT,
  output logic ready,
  output logic error
);
  localparam int unsigned QCW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned PCW = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES) : 1;
  localparam int unsigned RTW = $clog2(RETRIES + 2);
  localparam logic [3:0]  LAST_IDX = 4'd12;

  typedef enum logic [2:0] {WAIT_PWR, START, BYTE, ACK, STOP, NEXT, DONE, FAIL} state_t;

  state_t           state, state_n;
  logic [1:0]       q, q_n;
  logic [QCW-1:0]   qcnt, qcnt_n;
  logic [PCW-1:0]   pwr_cnt, pwr_cnt_n;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic [1:0]       byte_cnt, byte_cnt_n;
  logic [3:0]       idx, idx_n;
  logic [RTW-1:0]   retry, retry_n;
  logic             nack, nack_n;
  logic             scl_n, sda_n, ready_n, error_n;
  logic             tick, phase_end, restart;
  logic [7:0]       cur_byte;

  // Byte sel of register-table entry idx: 0 = write address, 1 = register, 2 = data
  function automatic logic [7:0] tx_byte(input logic [3:0] i, input logic [1:0] sel);
    logic [15:0] e;
    case (i)
      4'd0:    e = 16'h4110;
      4'd1:    e = 16'h9803;
      4'd2:    e = 16'h9AE0;
      4'd3:    e = 16'h9C30;
      4'd4:    e = 16'h9D61;
      4'd5:    e = 16'hA2A4;
      4'd6:    e = 16'hA3A4;
      4'd7:    e = 16'hE0D0;
      4'd8:    e = 16'hF900;
      4'd9:    e = 16'h1500;
      4'd10:   e = 16'h1630;
      4'd11:   e = 16'hAF06;
      default: e = 16'h96C0;
    endcase
    case (sel)
      2'd0:    tx_byte = {DEV_ADDR, 1'b0};
      2'd1:    tx_byte = e[15:8];
      default: tx_byte = e[7:0];
    endcase
  endfunction

  // {scl_oe, sda_oe} for quarter qq of the given phase; b is the data bit being sent
  function automatic logic [1:0] drive(input state_t st, input logic [1:0] qq, input logic b);
    case (st)
      START:   drive = (qq == 2'd0) ? 2'b00 : ((qq == 2'd3) ? 2'b11 : 2'b01);
      BYTE:    drive = {(qq == 2'd0) || (qq == 2'd3), ~b};
      ACK:     drive = {(qq == 2'd0) || (qq == 2'd3), 1'b0};
      STOP:    drive = (qq == 2'd0) ? 2'b11 : ((qq == 2'd1) ? 2'b01 : 2'b00);
      default: drive = 2'b00;
    endcase
  endfunction

`ifdef HDMI_CFG_HPD_EN
  logic int_meta, int_sync, pending, pending_n;

  always_ff @(posedge clock25 or negedge resetn) begin
    if (!resetn) begin
      int_meta <= 1'b0;
      int_sync <= 1'b0;
      pending  <= 1'b0;
    end else begin
      int_meta <= HDMI_TX_INT;
      int_sync <= int_meta;
      pending  <= pending_n;
    end
  end

  // A hot-plug seen mid-sequence waits here until the sequence finishes
  assign restart   = ((state == DONE) || (state == FAIL)) && (pending || int_sync);
  assign pending_n = restart ? 1'b0 : (pending | int_sync);
`else
  logic unused_int;
  assign unused_int = HDMI_TX_INT;
  assign restart    = 1'b0;
`endif

  always_ff @(posedge clock25 or negedge resetn) begin
    if (!resetn) begin
      state    <= WAIT_PWR;
      q        <= '0;
      qcnt     <= '0;
      pwr_cnt  <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      idx      <= '0;
      retry    <= '0;
      nack     <= 1'b0;
      scl_oe   <= 1'b0;
      sda_oe   <= 1'b0;
      ready    <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= state_n;
      q        <= q_n;
      qcnt     <= qcnt_n;
      pwr_cnt  <= pwr_cnt_n;
      bit_cnt  <= bit_cnt_n;
      byte_cnt <= byte_cnt_n;
      idx      <= idx_n;
      retry    <= retry_n;
      nack     <= nack_n;
      scl_oe   <= scl_n;
      sda_oe   <= sda_n;
      ready    <= ready_n;
      error    <= error_n;
    end
  end

  always_comb begin
    state_n    = state;
    q_n        = q;
    qcnt_n     = qcnt;
    pwr_cnt_n  = pwr_cnt;
    bit_cnt_n  = bit_cnt;
    byte_cnt_n = byte_cnt;
    idx_n      = idx;
    retry_n    = retry;
    nack_n     = nack;
    tick       = (qcnt == QCW'(CLK_DIV - 1));
    phase_end  = tick && (q == 2'd3);

    if (state inside {START, BYTE, ACK, STOP}) begin
      qcnt_n = tick ? '0 : qcnt + QCW'(1);
      if (tick) q_n = q + 2'd1;
    end

    case (state)
      WAIT_PWR: begin
        if (pwr_cnt == PCW'(POWERUP_CYCLES - 1)) state_n = START;
        else pwr_cnt_n = pwr_cnt + PCW'(1);
      end
      START: begin
        if (phase_end) begin
          state_n    = BYTE;
          byte_cnt_n = '0;
          bit_cnt_n  = '0;
          nack_n     = 1'b0;
        end
      end
      BYTE: begin
        if (phase_end) begin
          if (bit_cnt == 3'd7) state_n = ACK;
          else bit_cnt_n = bit_cnt + 3'd1;
        end
      end
      ACK: begin
        if (tick && (q == 2'd2)) nack_n = sda_in;
        if (phase_end) begin
          if (nack || (byte_cnt == 2'd2)) begin
            state_n = STOP;
          end else begin
            state_n    = BYTE;
            byte_cnt_n = byte_cnt + 2'd1;
            bit_cnt_n  = '0;
          end
        end
      end
      STOP: begin
        // Successful entries chain straight into the next START; the last one goes through NEXT
        if (phase_end) begin
          if (nack) begin
            if (retry == RTW'(RETRIES)) begin
              state_n = FAIL;
            end else begin
              retry_n = retry + RTW'(1);
              state_n = START;
            end
          end else if (idx == LAST_IDX) begin
            state_n = NEXT;
          end else begin
            idx_n   = idx + 4'd1;
            retry_n = '0;
            state_n = START;
          end
        end
      end
      NEXT: begin
        retry_n = '0;
        state_n = DONE;
      end
      DONE, FAIL: begin
        if (restart) begin
          state_n = START;
          idx_n   = '0;
          retry_n = '0;
          q_n     = '0;
          qcnt_n  = '0;
        end
      end
      default: state_n = WAIT_PWR;
    endcase

    cur_byte         = tx_byte(idx_n, byte_cnt_n);
    {scl_n, sda_n}   = drive(state_n, q_n, cur_byte[~bit_cnt_n]);
    ready_n          = (state_n == DONE);
    error_n          = (state_n == FAIL) ? 1'b1 : (restart ? 1'b0 : error);
  end

endmodule
